// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants and helpers for the counter blocks
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // All-ones value for a field of w bits (1..32), right-aligned in 32 bits.
  function automatic logic [31:0] all_ones(input int unsigned w);
    return 32'hFFFF_FFFF >> (32 - w);
  endfunction

endpackage

// File: rtl/wrap_tally.sv
// rtl/wrap_tally.sv - WRAP_W-bit event tally with synchronous clear and increment
module wrap_tally #(
  parameter int unsigned WRAP_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              clear_i,
  input  logic              inc_i,
  output logic [WRAP_W-1:0] cnt_o
);

  logic [WRAP_W-1:0] cnt_d;
  logic [WRAP_W-1:0] cnt_q;

  // Clear wins over increment; the tally rolls over silently.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + WRAP_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/updown_mod_counter.sv
// rtl/updown_mod_counter.sv - up/down modulus counter with tc pulse and wrap tally
// Define UPDOWN_MOD_COUNTER_SATURATE_EN to saturate at the bounds instead of wrapping.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned WRAP_W    = 8,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              en_i,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic [WIDTH-1:0]  load_val_i,
  input  logic              up_down_i,
  input  logic [WIDTH-1:0]  mod_i,
  output logic [WIDTH-1:0]  count_o,
  output logic              tc_o,
  output logic [WRAP_W-1:0] wrap_cnt_o
);

  localparam logic [WIDTH-1:0] CNT_MASK = WIDTH'(all_ones(WIDTH));
  localparam logic [WIDTH-1:0] RST_CNT  = WIDTH'(RESET_VAL) & CNT_MASK;

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;
  logic             tc_d;
  logic             tc_q;
  logic             tally_inc;
  logic             tally_clr;

  always_comb begin
    count_d   = count_q;
    tc_d      = 1'b0;
    tally_inc = 1'b0;
    tally_clr = 1'b0;
    if (clear_i) begin
      count_d   = '0;
      tally_clr = 1'b1;
    end else if (load_i) begin
      count_d = (load_val_i > mod_i) ? mod_i : load_val_i;
    end else if (en_i) begin
      if (up_down_i == DIR_UP) begin
        // >= also catches a count left above a freshly lowered modulus.
        if (count_q >= mod_i) begin
          tc_d = 1'b1;
`ifdef UPDOWN_MOD_COUNTER_SATURATE_EN
          count_d = mod_i;
`else
          count_d   = '0;
          tally_inc = 1'b1;
`endif
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          tc_d = 1'b1;
`ifndef UPDOWN_MOD_COUNTER_SATURATE_EN
          count_d   = mod_i;
          tally_inc = 1'b1;
`endif
        end else if (count_q > mod_i) begin
          count_d = mod_i;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      count_q <= RST_CNT;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  // In saturating mode tally_inc is never raised, so the tally stays at 0.
  wrap_tally #(
    .WRAP_W(WRAP_W)
  ) u_wrap_tally (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .clear_i (tally_clr),
    .inc_i   (tally_inc),
    .cnt_o   (wrap_cnt_o)
  );

  assign count_o = count_q;
  assign tc_o    = tc_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// tb/tb_updown_mod_counter.sv - directed self-checking bench for updown_mod_counter
module tb_updown_mod_counter;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned WRAP_W = 4;

  logic              clk_i = 1'b0;
  logic              reset_ni;
  logic              en_i;
  logic              clear_i;
  logic              load_i;
  logic [WIDTH-1:0]  load_val_i;
  logic              up_down_i;
  logic [WIDTH-1:0]  mod_i;
  logic [WIDTH-1:0]  count_o;
  logic              tc_o;
  logic [WRAP_W-1:0] wrap_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  updown_mod_counter #(
    .WIDTH    (WIDTH),
    .WRAP_W   (WRAP_W),
    .RESET_VAL(0)
  ) dut (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .en_i      (en_i),
    .clear_i   (clear_i),
    .load_i    (load_i),
    .load_val_i(load_val_i),
    .up_down_i (up_down_i),
    .mod_i     (mod_i),
    .count_o   (count_o),
    .tc_o      (tc_o),
    .wrap_cnt_o(wrap_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int sat_cnt[6];
    int sat_tc[6];
`ifdef UPDOWN_MOD_COUNTER_SATURATE_EN
    sat_cnt = '{1, 2, 3, 3, 3, 3};
    sat_tc  = '{0, 0, 0, 1, 1, 1};
`else
    sat_cnt = '{1, 2, 3, 0, 1, 2};
    sat_tc  = '{0, 0, 0, 1, 0, 0};
`endif

    reset_ni   = 1'b0;
    en_i       = 1'b1;
    clear_i    = 1'b0;
    load_i     = 1'b0;
    load_val_i = '0;
    up_down_i  = 1'b1;
    mod_i      = 16'd9;

    // Reset state before any clock edge
    #3;
    chk("rst_cnt", 32'(count_o), 0);
    chk("rst_tc", 32'(tc_o), 0);
    chk("rst_wrap", 32'(wrap_cnt_o), 0);
    @(negedge clk_i);
    reset_ni = 1'b1;

    // 1: up-count mod 9 for 25 cycles
    for (int k = 1; k <= 25; k++) begin
      tick();
      chk("t1_cnt", 32'(count_o), 32'(k % 10));
      chk("t1_tc", 32'(tc_o), (k % 10 == 0) ? 1 : 0);
    end
    chk("t1_wrap", 32'(wrap_cnt_o), 2);

    // 2: load 2, mod 5, count down through the wrap
    mod_i = 16'd5; en_i = 1'b0; load_i = 1'b1; load_val_i = 16'd2;
    tick();
    chk("t2_load", 32'(count_o), 2);
    load_i = 1'b0; en_i = 1'b1; up_down_i = 1'b0;
    tick(); chk("t2_c1", 32'(count_o), 1); chk("t2_tc1", 32'(tc_o), 0);
    tick(); chk("t2_c2", 32'(count_o), 0); chk("t2_tc2", 32'(tc_o), 0);
    tick(); chk("t2_c3", 32'(count_o), 5); chk("t2_tc3", 32'(tc_o), 1);
    chk("t2_wrap", 32'(wrap_cnt_o), 3);
    tick(); chk("t2_c4", 32'(count_o), 4); chk("t2_tc4", 32'(tc_o), 0);

    // 3: clear beats load beats enable
    mod_i = 16'd9; up_down_i = 1'b1;
    clear_i = 1'b1; load_i = 1'b1; load_val_i = 16'd7; en_i = 1'b1;
    tick();
    chk("t3_clr_cnt", 32'(count_o), 0);
    chk("t3_clr_wrap", 32'(wrap_cnt_o), 0);
    chk("t3_clr_tc", 32'(tc_o), 0);
    clear_i = 1'b0;
    tick();
    chk("t3_load_cnt", 32'(count_o), 7);
    load_i = 1'b0; en_i = 1'b0;
    tick();
    chk("t3_hold_cnt", 32'(count_o), 7);

    // 4: load clamp and modulus lowered mid-count
    mod_i = 16'd100; load_i = 1'b1; load_val_i = 16'd200;
    tick();
    chk("t4_clamp", 32'(count_o), 100);
    load_i = 1'b0; mod_i = 16'd50; en_i = 1'b1; up_down_i = 1'b1;
    tick();
    chk("t4_up_cnt", 32'(count_o), 0);
    chk("t4_up_tc", 32'(tc_o), 1);
    chk("t4_up_wrap", 32'(wrap_cnt_o), 1);
    mod_i = 16'd100; load_i = 1'b1; load_val_i = 16'd80; en_i = 1'b0;
    tick();
    chk("t4_load80", 32'(count_o), 80);
    chk("t4_load_tc", 32'(tc_o), 0);
    load_i = 1'b0; mod_i = 16'd50; en_i = 1'b1; up_down_i = 1'b0;
    tick();
    chk("t4_dn_cnt", 32'(count_o), 50);
    chk("t4_dn_tc", 32'(tc_o), 0);
    chk("t4_dn_wrap", 32'(wrap_cnt_o), 1);

    // 5: asynchronous reset between edges
    mod_i = 16'd100; load_i = 1'b1; load_val_i = 16'd37; en_i = 1'b0; up_down_i = 1'b1;
    tick();
    chk("t5_pre", 32'(count_o), 37);
    load_i = 1'b0; en_i = 1'b1;
    #2 reset_ni = 1'b0;
    #1;
    chk("t5_async_cnt", 32'(count_o), 0);
    chk("t5_async_tc", 32'(tc_o), 0);
    chk("t5_async_wrap", 32'(wrap_cnt_o), 0);
    tick();
    chk("t5_held", 32'(count_o), 0);
    @(negedge clk_i);
    reset_ni = 1'b1;
    tick();
    chk("t5_resume", 32'(count_o), 1);

    // 6: mod 0 wraps every enabled cycle, both directions; tally rolls over
    mod_i = 16'd0; clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      up_down_i = (k > 10) ? 1'b0 : 1'b1;
      tick();
      chk("t6_cnt", 32'(count_o), 0);
      chk("t6_tc", 32'(tc_o), 1);
    end
    chk("t6_wrap", 32'(wrap_cnt_o), 4);
    en_i = 1'b0;
    tick();
    chk("t6_idle_tc", 32'(tc_o), 0);
    chk("t6_idle_wrap", 32'(wrap_cnt_o), 4);

    // 6b: mod 3 up for 6 cycles (saturating or wrapping per build)
    clear_i = 1'b1; mod_i = 16'd3; up_down_i = 1'b1;
    tick();
    clear_i = 1'b0; en_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t6b_cnt", 32'(count_o), 32'(sat_cnt[k]));
      chk("t6b_tc", 32'(tc_o), 32'(sat_tc[k]));
    end
`ifdef UPDOWN_MOD_COUNTER_SATURATE_EN
    chk("t6b_wrap", 32'(wrap_cnt_o), 0);
`else
    chk("t6b_wrap", 32'(wrap_cnt_o), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
